// File: rtl/ctrl_sequencer.sv
//==============================================================================
// Module      : ctrl_sequencer
// Description : Multi-cycle control FSM for the register-file/ALU datapath.
//               Sequences FETCH -> DECODE -> EXEC -> WB. It emits a one-cycle
//               pc_en strobe per instruction and provides a run/busy handshake,
//               halt detection and a retired-instruction counter.
//               Optional macro CTRL_SEQ_ILLEGAL_TRAP_EN: when it is defined,
//               illegal opcodes halt the sequencer. When it is undefined,
//               illegal opcodes retire as NOPs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ctrl_sequencer #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LI    = 6'b000001,
    parameter logic [5:0] OP_HALT  = 6'b111111,
    parameter logic [5:0] FN_SLL   = 6'b000000,
    parameter logic [5:0] FN_SRL   = 6'b000010,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             run,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    output logic             pc_en,
    output logic             Reg_write,
    output logic             ALU_op,
    output logic             ALU_src,
    output logic             Writeback_src,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [5:0]       w_op_sel;
    logic [5:0]       w_fn_sel;
    logic             w_dec_legal;
    logic             w_dec_halt;
    logic             w_sel_rtype;
    logic             w_sel_li;
    logic             w_ctrl_phase;
    logic             w_pc_en_nxt;
    logic             w_reg_write_nxt;
    logic             w_alu_op_nxt;
    logic             w_alu_src_nxt;
    logic             w_wb_src_nxt;
    logic             w_busy_nxt;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] r_count;

    assign state       = r_state;
    assign instr_count = r_count;

    // Next-state and next-output decode. Outputs are computed one cycle ahead
    // so that they can be registered with the state.
    always_comb begin
        w_next_state    = r_state;
        w_op_sel        = r_opcode;
        w_fn_sel        = r_funct;
        w_dec_legal     = 1'b0;
        w_dec_halt      = 1'b0;
        w_sel_rtype     = 1'b0;
        w_sel_li        = 1'b0;
        w_ctrl_phase    = 1'b0;
        w_pc_en_nxt     = 1'b0;
        w_reg_write_nxt = 1'b0;
        w_alu_op_nxt    = 1'b0;
        w_alu_src_nxt   = 1'b0;
        w_wb_src_nxt    = 1'b0;
        w_busy_nxt      = 1'b0;
        w_halted_nxt    = 1'b0;

        // The opcode is captured on the edge that leaves DECODE. On that edge
        // the incoming value steers both the branch and the first EXEC
        // controls. The latched copy is used afterwards.
        w_dec_legal = (Opcode == OP_RTYPE) || (Opcode == OP_LI);
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        w_dec_halt  = (Opcode == OP_HALT) || !w_dec_legal;
`else
        w_dec_halt  = (Opcode == OP_HALT);
`endif

        case (r_state)
            S_IDLE:   if (run) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = w_dec_halt ? S_HALTED : S_EXEC;
            S_EXEC:   w_next_state = S_WB;
            S_WB:     w_next_state = run ? S_FETCH : S_IDLE;
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase

        if (r_state == S_DECODE) begin
            w_op_sel = Opcode;
            w_fn_sel = Funct;
        end
        w_sel_rtype  = (w_op_sel == OP_RTYPE);
        w_sel_li     = (w_op_sel == OP_LI);
        w_ctrl_phase = (w_next_state == S_EXEC) || (w_next_state == S_WB);

        w_pc_en_nxt     = (w_next_state == S_FETCH);
        w_alu_op_nxt    = w_ctrl_phase && w_sel_rtype;
        w_alu_src_nxt   = w_ctrl_phase && w_sel_rtype &&
                          ((w_fn_sel == FN_SLL) || (w_fn_sel == FN_SRL));
        w_wb_src_nxt    = w_ctrl_phase && w_sel_li;
        w_reg_write_nxt = (w_next_state == S_WB) && (w_sel_rtype || w_sel_li);
        w_busy_nxt      = (w_next_state != S_IDLE) && (w_next_state != S_HALTED);
        w_halted_nxt    = (w_next_state == S_HALTED);
    end

    // State register and registered (Moore) control outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            pc_en         <= 1'b0;
            Reg_write     <= 1'b0;
            ALU_op        <= 1'b0;
            ALU_src       <= 1'b0;
            Writeback_src <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            pc_en         <= w_pc_en_nxt;
            Reg_write     <= w_reg_write_nxt;
            ALU_op        <= w_alu_op_nxt;
            ALU_src       <= w_alu_src_nxt;
            Writeback_src <= w_wb_src_nxt;
            busy          <= w_busy_nxt;
            halted        <= w_halted_nxt;
        end
    end

    // Instruction latch: hold Opcode/Funct as seen in DECODE for EXEC and WB.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= Opcode;
            r_funct  <= Funct;
        end
    end

    // Retired-instruction counter. It advances once per WB, and every
    // instruction that reaches WB has retired.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (r_state == S_WB) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
